vector_mem_sequencer: RTL and testbench
=======================================

// Module: vector_mem_sequencer
// PURPOSE
//  Sequences one vector load/store between the vector unit and the word-wide data memory.
//  Splits a VEC_W-bit access into LANES word transactions at consecutive addresses.
//  Holds stall_cpu while busy and assembles load data into a full vector.
//  Sits between decode/vector register file and the shared data-memory port.
// PARAMETERS
//  VEC_W   128  vector width in bits
//  WORD_W  32   memory word width in bits; LANES = VEC_W/WORD_W (integer, >=2)
//  ADDR_W  32   byte address width
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous reset, active-high
//  req_valid   in   1       vector memory op requested
//  req_store   in   1       1 = vector store, 0 = vector load
//  req_addr    in   ADDR_W  base byte address (lane 0)
//  req_vector  in   VEC_W   store data; lane i = bits [i*WORD_W +: WORD_W]
//  req_ready   out  1       sequencer can accept a request this cycle
//  stall_cpu   out  1       pipeline hold
//  mem_addr    out  ADDR_W  memory byte address
//  mem_wdata   out  WORD_W  memory write data
//  mem_wen     out  1       memory write strobe
//  mem_ren     out  1       memory read strobe; mem_rdata valid the following cycle
//  mem_rdata   in   WORD_W  memory read data
//  ld_vector   out  VEC_W   assembled load result
//  ld_valid    out  1       one-cycle pulse, ld_vector valid
//  st_done     out  1       one-cycle pulse, store complete
// BEHAVIOUR
//  FSM states: IDLE, ST, LD, LD_TAIL, DONE. Lane counter is log2(LANES) bits.
//  Accept = req_valid & req_ready; req_ready = (state==IDLE | state==DONE).
//  On accept: latch req_addr, req_vector, req_store; lane cnt=0; go ST or LD.
//  ST: each cycle mem_wen=1, mem_addr=base+cnt*STEP, mem_wdata=lane cnt; after lane LANES-1 -> DONE.
//  LD: each cycle mem_ren=1, mem_addr as for ST; rdata captured into lane cnt-1 the next cycle.
//    After lane LANES-1 issued -> LD_TAIL; LD_TAIL captures last lane -> DONE.
//  DONE: one cycle; st_done=1 (store) or ld_valid=1 (load); back-to-back accept allowed here, else -> IDLE.
//  ld_vector holds its value until the next load completes. No other state changes it.
//  STEP = WORD_W/8 bytes. Address arithmetic is modulo 2^ADDR_W (wraps, no error).
//  Latency (LANES=4): store writes on cycles 1-4 after accept, st_done on cycle 5.
//    Load reads on cycles 1-4, ld_valid on cycle 6.
//  stall_cpu = (state in ST/LD/LD_TAIL) | (req_valid & req_ready). It is combinational, so the request cycle also stalls.
//    stall_cpu is low in DONE unless a new request is accepted.
//  mem_wen and mem_ren are never asserted together. Both are 0 in IDLE, LD_TAIL and DONE.
//  Inputs changing after accept are ignored. req_valid while busy is held off by stall_cpu and is not lost.
//  Reset (asserted any time, including mid-sequence): state=IDLE, cnt=0; mem_* outputs, ld_valid, st_done=0; ld_vector=0.
//    An aborted store may leave partial writes. An aborted load never pulses ld_valid.
// CONFIGURATION
//  VSEQ_STRIDE_EN defined: adds input req_stride [ADDR_W-1:0], latched on accept.
//    Lane i address = base + i*req_stride (mod 2^ADDR_W). Stride 0 hits the same word LANES times.
//  Undefined: port absent, stride fixed at WORD_W/8.
// TESTING
//  1. Store base 0x100, vector 128'h44444444_33333333_22222222_11111111
//     -> writes 0x100=11111111, 0x104=22222222, 0x108=33333333, 0x10C=44444444 on consecutive cycles; st_done on cycle 5.
//  2. Load base 0x200, memory returns A0,B1,C2,D3 -> ld_vector=128'h000000D3_000000C2_000000B1_000000A0; ld_valid on cycle 6.
//  3. Store base 0xFFFFFFF8 -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
//  4. Store, then load presented in its DONE cycle -> load accepted with no idle gap.
//     stall_cpu stays high continuously; no wen/ren overlap.
//  5. rst pulsed after 2nd load read -> all outputs 0 asynchronously; no ld_valid.
//     A new request after reset completes normally.
//  6. VSEQ_STRIDE_EN, stride 0x10, base 0x0 load -> reads at 0x00, 0x10, 0x20, 0x30.

Source files
------------

// File: rtl/vector_mem_sequencer.sv
// Vector memory sequencer: splits one VEC_W-bit load/store into LANES word
// transactions on the shared data-memory port, stalls the pipeline while busy
// and assembles load data into a full vector.
// Optional feature macro: VSEQ_STRIDE_EN adds a per-request byte stride input.
module vector_mem_sequencer #(
  parameter int unsigned VEC_W  = 128,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  req_vector,
`ifdef VSEQ_STRIDE_EN
  input  logic [ADDR_W-1:0] req_stride,
`endif
  output logic              req_ready,
  output logic              stall_cpu,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [VEC_W-1:0]  ld_vector,
  output logic              ld_valid,
  output logic              st_done
);

  localparam int unsigned Lanes = VEC_W / WORD_W;
  localparam int unsigned CntW  = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(Lanes - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSt,
    StLd,
    StLdTail,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [VEC_W-1:0]    buf_q, buf_d;
  logic                store_q, store_d;
  logic [VEC_W-1:0]    ld_vector_q, ld_vector_d;
  logic [ADDR_W-1:0]   stride;
  logic                accept;
  logic                busy;

`ifdef VSEQ_STRIDE_EN
  logic [ADDR_W-1:0]   stride_q, stride_d;
  assign stride = stride_q;
`else
  localparam logic [ADDR_W-1:0] Step = ADDR_W'(WORD_W / 8);
  assign stride = Step;
`endif

  assign req_ready = (state_q == StIdle) || (state_q == StDone);
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == StSt) || (state_q == StLd) || (state_q == StLdTail);

  // Next-state: addr_q runs ahead by one stride per issued lane. buf_q holds
  // store data shifted down one lane per write, or load data shifted in from
  // the top so lane 0 ends up at the bottom after LANES captures.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    store_d     = store_q;
    ld_vector_d = ld_vector_q;
`ifdef VSEQ_STRIDE_EN
    stride_d    = stride_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d = req_store ? StSt : StLd;
          cnt_d   = '0;
          addr_d  = req_addr;
          buf_d   = req_vector;
          store_d = req_store;
`ifdef VSEQ_STRIDE_EN
          stride_d = req_stride;
`endif
        end
      end
      StSt: begin
        buf_d  = buf_q >> WORD_W;
        addr_d = addr_q + stride;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastLane) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StLd: begin
        addr_d = addr_q + stride;
        cnt_d  = cnt_q + CntW'(1);
        // Read data lags the strobe by one cycle, so lane 0 arrives at cnt 1.
        if (cnt_q != '0) begin
          buf_d = {mem_rdata, buf_q[VEC_W-1:WORD_W]};
        end
        if (cnt_q == LastLane) begin
          state_d = StLdTail;
          cnt_d   = '0;
        end
      end
      StLdTail: begin
        // Publish only when complete so ld_vector never shows a partial load.
        ld_vector_d = {mem_rdata, buf_q[VEC_W-1:WORD_W]};
        state_d     = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      buf_q       <= '0;
      store_q     <= 1'b0;
      ld_vector_q <= '0;
`ifdef VSEQ_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
      store_q     <= store_d;
      ld_vector_q <= ld_vector_d;
`ifdef VSEQ_STRIDE_EN
      stride_q    <= stride_d;
`endif
    end
  end

  // Outputs decoded from state; memory bus is driven to zero when idle.
  always_comb begin
    stall_cpu = busy || accept;
    mem_wen   = (state_q == StSt);
    mem_ren   = (state_q == StLd);
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_wen || mem_ren) begin
      mem_addr = addr_q;
    end
    if (mem_wen) begin
      mem_wdata = buf_q[WORD_W-1:0];
    end
    st_done   = (state_q == StDone) && store_q;
    ld_valid  = (state_q == StDone) && !store_q;
    ld_vector = ld_vector_q;
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed table-driven bench for vector_mem_sequencer (default 128/32/32 build).
module tb_vector_mem_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_store;
  logic [31:0]  req_addr;
  logic [127:0] req_vector;
`ifdef VSEQ_STRIDE_EN
  logic [31:0]  req_stride;
`endif
  logic         req_ready;
  logic         stall_cpu;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_wen;
  logic         mem_ren;
  logic [31:0]  mem_rdata;
  logic [127:0] ld_vector;
  logic         ld_valid;
  logic         st_done;

  int errors = 0;
  int checks = 0;

  vector_mem_sequencer #(
    .VEC_W (128),
    .WORD_W(32),
    .ADDR_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_store (req_store),
    .req_addr  (req_addr),
    .req_vector(req_vector),
`ifdef VSEQ_STRIDE_EN
    .req_stride(req_stride),
`endif
    .req_ready (req_ready),
    .stall_cpu (stall_cpu),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata),
    .ld_vector (ld_vector),
    .ld_valid  (ld_valid),
    .st_done   (st_done)
  );

  always #5 clk = ~clk;

  // Memory read model: fixed words at 0x200.., a recognisable pattern elsewhere.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h200: rd_model = 32'h000000A0;
      32'h204: rd_model = 32'h000000B1;
      32'h208: rd_model = 32'h000000C2;
      32'h20C: rd_model = 32'h000000D3;
      default: rd_model = {16'hBEEF, a[15:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= rd_model(mem_addr);
  end

  // Write and read strobes must never overlap.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (mem_wen && mem_ren) begin
        errors++;
        $display("FAIL wen_ren_overlap: wen=%b ren=%b required not both 1", mem_wen, mem_ren);
      end
    end
  end

  typedef struct {
    logic         v;
    logic         st;
    logic [31:0]  a;
    logic [127:0] vec;
    logic [69:0]  exp;
    logic         chk_lv;
    logic [127:0] exp_lv;
  } row_t;

  row_t rows[$];

  localparam logic [127:0] V1  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LD2 = 128'h000000D3_000000C2_000000B1_000000A0;
  localparam logic [127:0] V3  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] V4  = 128'h0000000F_0000000E_0000000D_0000000C;
  localparam logic [127:0] LD4 = 128'hBEEF040C_BEEF0408_BEEF0404_BEEF0400;

  function automatic row_t mk(input logic v, input logic st, input logic [31:0] a,
                              input logic [127:0] vec, input logic rdy, input logic stl,
                              input logic wen, input logic ren, input logic [31:0] ma,
                              input logic [31:0] wd, input logic dn, input logic lv,
                              input logic clv, input logic [127:0] elv);
    row_t r;
    r.v      = v;
    r.st     = st;
    r.a      = a;
    r.vec    = vec;
    r.exp    = {rdy, stl, wen, ren, ma, wd, dn, lv};
    r.chk_lv = clv;
    r.exp_lv = elv;
    return r;
  endfunction

  function automatic logic [69:0] obs();
    return {req_ready, stall_cpu, mem_wen, mem_ren, mem_addr, mem_wdata, st_done, ld_valid};
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Returns 1 if the selected pulse appears within the cycle budget.
  task automatic wait_pulse(input bit want_ld, output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (want_ld ? ld_valid : st_done) got = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] ren_addrs[$];
    bit got;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_addr   = '0;
    req_vector = '0;
`ifdef VSEQ_STRIDE_EN
    req_stride = 32'h4;
`endif

    // Test 1: store base 0x100, writes on cycles 1-4, st_done on cycle 5.
    rows.push_back(mk(1, 1, 32'h100, V1, 1, 1, 0, 0, 0, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h100, 32'h11111111, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h104, 32'h22222222, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h108, 32'h33333333, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h10C, 32'h44444444, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, 1, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, 0, 0, 1, '0));
    // Test 2: load base 0x200, reads on cycles 1-4, tail, ld_valid on cycle 6.
    rows.push_back(mk(1, 0, 32'h200, '0, 1, 1, 0, 0, 0, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 1, 32'h200, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 1, 32'h204, 0, 0, 0, 1, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 1, 32'h208, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 1, 32'h20C, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 0, 0, 0, 0, 0, 1, '0));
    rows.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, 0, 1, 1, LD2));
    rows.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, 0, 0, 1, LD2));
    // Test 3: store wrapping past 2^32.
    rows.push_back(mk(1, 1, 32'hFFFFFFF8, V3, 1, 1, 0, 0, 0, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'hFFFFFFF8, 32'hAAAAAAAA, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'hFFFFFFFC, 32'hBBBBBBBB, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h00000000, 32'hCCCCCCCC, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h00000004, 32'hDDDDDDDD, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, 1, 0, 1, LD2));
    rows.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, 0, 0, 1, LD2));
    // Test 4: store, then load accepted in the DONE cycle; stall stays high.
    rows.push_back(mk(1, 1, 32'h300, V4, 1, 1, 0, 0, 0, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h300, 32'h0000000C, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h304, 32'h0000000D, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h308, 32'h0000000E, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 1, 0, 32'h30C, 32'h0000000F, 0, 0, 0, '0));
    rows.push_back(mk(1, 0, 32'h400, '0, 1, 1, 0, 0, 0, 0, 1, 0, 1, LD2));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 1, 32'h400, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 1, 32'h404, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 1, 32'h408, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 1, 32'h40C, 0, 0, 0, 1, LD2));
    rows.push_back(mk(0, 0, 0, '0, 0, 1, 0, 0, 0, 0, 0, 0, 0, '0));
    rows.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, 0, 1, 1, LD4));
    rows.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, 0, 0, 1, LD4));

    // Reset state while rst is held.
    #12;
    check("reset_outputs", 256'(obs()), 256'({1'b1, 69'b0}));
    check("reset_ld_vector", 256'(ld_vector), 256'(0));
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (rows[i]) begin
      req_valid  = rows[i].v;
      req_store  = rows[i].st;
      req_addr   = rows[i].a;
      req_vector = rows[i].vec;
      @(negedge clk);
      check($sformatf("row%0d_outputs", i), 256'(obs()), 256'(rows[i].exp));
      if (rows[i].chk_lv) check($sformatf("row%0d_ld_vector", i), 256'(ld_vector),
                                256'(rows[i].exp_lv));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;

    // Test 5: reset mid-load, after the second read has been issued.
    req_valid = 1'b1;
    req_store = 1'b0;
    req_addr  = 32'h200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_outputs", 256'(obs()), 256'({1'b1, 69'b0}));
    check("abort_ld_vector", 256'(ld_vector), 256'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_ld_valid%0d", k), 256'(ld_valid), 256'(0));
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle%0d", k), 256'(obs()), 256'({1'b1, 69'b0}));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 32'h200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_pulse(1'b1, got);
    check("reload_ld_valid_seen", 256'(got), 256'(1));
    check("reload_ld_vector", 256'(ld_vector), 256'(LD2));
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_addr   = 32'h500;
    req_vector = V1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_pulse(1'b0, got);
    check("restore_st_done_seen", 256'(got), 256'(1));
    check("restore_ld_vector_held", 256'(ld_vector), 256'(LD2));
    @(posedge clk);
    #1;

`ifdef VSEQ_STRIDE_EN
    // Test 6: stride 0x10 load from 0.
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_addr   = 32'h0;
    req_stride = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_stride = 32'h4;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_ren) ren_addrs.push_back(mem_addr);
      if (ld_valid) got = 1'b1;
    end
    check("stride_ld_valid_seen", 256'(got), 256'(1));
    check("stride_read_count", 256'(ren_addrs.size()), 256'(4));
    if (ren_addrs.size() == 4) begin
      check("stride_addr0", 256'(ren_addrs[0]), 256'(32'h00));
      check("stride_addr1", 256'(ren_addrs[1]), 256'(32'h10));
      check("stride_addr2", 256'(ren_addrs[2]), 256'(32'h20));
      check("stride_addr3", 256'(ren_addrs[3]), 256'(32'h30));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
